// File: rtl/semaforo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : semaforo_pkg
// Description : Shared types, timing defaults and colour decode helpers for
//               the two-way intersection scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package semaforo_pkg;

    // Light colour bus encoding, consumed unchanged by the tricolour decoders
    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        RED    = 2'b10,
        OFF    = 2'b11
    } color_t;

    // Scheduler state codes (also exported on the debug bus)
    typedef enum logic [3:0] {
        A_GRN = 4'd0,
        A_YEL = 4'd1,
        AR_AB = 4'd2,
        B_GRN = 4'd3,
        B_YEL = 4'd4,
        AR_BA = 4'd5,
        PED   = 4'd6,
        NIGHT = 4'd7
    } sched_state_t;

    // Default timing
    localparam int DEF_TICK_DIV    = 50_000_000;
    localparam int DEF_T_MIN_GREEN = 5;
    localparam int DEF_T_YELLOW    = 2;
    localparam int DEF_T_ALLRED    = 1;
    localparam int DEF_T_WALK      = 4;

    // Width of the per-state tick counter (durations up to 256 ticks)
    localparam int CNT_W = 8;

    // Colour shown to direction A in a given state
    function automatic color_t color_a(sched_state_t s, logic blink);
        color_t c;
        c = RED;
        case (s)
            A_GRN:   c = GREEN;
            A_YEL:   c = YELLOW;
            NIGHT:   c = blink ? YELLOW : OFF;
            default: c = RED;
        endcase
        return c;
    endfunction

    // Colour shown to direction B in a given state
    function automatic color_t color_b(sched_state_t s, logic blink);
        color_t c;
        c = RED;
        case (s)
            B_GRN:   c = GREEN;
            B_YEL:   c = YELLOW;
            NIGHT:   c = blink ? YELLOW : OFF;
            default: c = RED;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/semaforo_sched_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : Free-running clock divider producing a one-cycle tick every
//               TICK_DIV cycles; restartable by a synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    output logic o_tick
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] r_div;

    assign o_tick = (r_div == C_DIV_LAST);

    // Divider counts 0..TICK_DIV-1, restarting on wrap or on a state change
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_div <= '0;
        end else if (o_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/semaforo_sched.sv
`default_nettype none
// ============================================================================
// Module      : semaforo_sched
// Description : Timed green/yellow/all-red scheduler for a two-way junction
//               with latched pedestrian service and night-flash mode.
// Revision    : 1.0 - initial release
// ============================================================================
module semaforo_sched
    import semaforo_pkg::*;
#(
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int T_MIN_GREEN = DEF_T_MIN_GREEN,
    parameter int T_YELLOW    = DEF_T_YELLOW,
    parameter int T_ALLRED    = DEF_T_ALLRED,
    parameter int T_WALK      = DEF_T_WALK
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_req_A,
    input  logic       i_req_B,
    input  logic       i_ped_btn,
    input  logic       i_night,
    output logic [1:0] o_LA,
    output logic [1:0] o_LB,
    output logic       o_walk,
    output logic [3:0] o_state
);

    // Last tick-counter value of each timed phase
    localparam logic [CNT_W-1:0] C_GRN_LAST  = CNT_W'(T_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] C_YEL_LAST  = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] C_AR_LAST   = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] C_WALK_LAST = CNT_W'(T_WALK - 1);

    sched_state_t     r_state;
    sched_state_t     w_next;
    logic [CNT_W-1:0] r_tcnt;
    logic [CNT_W-1:0] w_last;
    logic             r_ped_pend;
    logic             r_blink;
    logic             w_blink_next;
    logic             r_next_dir_a;
    logic             w_next_dir_a;
    logic             w_tick;
    logic             w_done;
    logic             w_change;
    color_t           r_la;
    color_t           r_lb;
    logic             r_walk;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (w_change),
        .o_tick  (w_tick)
    );

    // Next-state selection; green exits need min green elapsed plus demand
    always_comb begin
        w_next       = r_state;
        w_next_dir_a = r_next_dir_a;
        case (r_state)
            A_GRN, B_GRN: w_last = C_GRN_LAST;
            A_YEL, B_YEL: w_last = C_YEL_LAST;
            AR_AB, AR_BA: w_last = C_AR_LAST;
            PED:          w_last = C_WALK_LAST;
            default:      w_last = '0;
        endcase
        // Counter saturates at w_last, so equality also covers "at least"
        w_done = w_tick && (r_tcnt == w_last);
        case (r_state)
            A_GRN: if (w_done && (i_req_B || r_ped_pend || i_night)) w_next = A_YEL;
            A_YEL: if (w_done) w_next = AR_AB;
            AR_AB: begin
                if (w_done) begin
                    if (i_night) begin
                        w_next = NIGHT;
                    end else if (r_ped_pend) begin
                        w_next       = PED;
                        w_next_dir_a = 1'b0;
                    end else begin
                        w_next = B_GRN;
                    end
                end
            end
            B_GRN: if (w_done && (i_req_A || r_ped_pend || i_night)) w_next = B_YEL;
            B_YEL: if (w_done) w_next = AR_BA;
            AR_BA: begin
                if (w_done) begin
                    if (i_night) begin
                        w_next = NIGHT;
                    end else if (r_ped_pend) begin
                        w_next       = PED;
                        w_next_dir_a = 1'b1;
                    end else begin
                        w_next = A_GRN;
                    end
                end
            end
            PED:     if (w_done) w_next = r_next_dir_a ? A_GRN : B_GRN;
            NIGHT:   if (!i_night) w_next = AR_BA;
            default: w_next = A_GRN;
        endcase
        w_change = (w_next != r_state);
        // Blink runs only while staying in NIGHT and is cleared on exit
        if (w_next != NIGHT) begin
            w_blink_next = 1'b0;
        end else if (r_state == NIGHT && w_tick) begin
            w_blink_next = ~r_blink;
        end else begin
            w_blink_next = r_blink;
        end
    end

    // State, tick counter, pedestrian latch and Moore output registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= A_GRN;
            r_tcnt       <= '0;
            r_ped_pend   <= 1'b0;
            r_blink      <= 1'b0;
            r_next_dir_a <= 1'b0;
            r_la         <= GREEN;
            r_lb         <= RED;
            r_walk       <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_blink      <= w_blink_next;
            r_next_dir_a <= w_next_dir_a;
            if (w_change) begin
                r_tcnt <= '0;
            end else if (w_tick && (r_tcnt != w_last)) begin
                r_tcnt <= r_tcnt + 1'b1;
            end
            // Entry into PED wins over a coincident press; presses in PED are dropped
            if (w_change && (w_next == PED)) begin
                r_ped_pend <= 1'b0;
            end else if ((r_state != PED) && i_ped_btn) begin
                r_ped_pend <= 1'b1;
            end
            // Decoding the next state keeps outputs aligned with the state register
            r_la   <= color_a(w_next, w_blink_next);
            r_lb   <= color_b(w_next, w_blink_next);
            r_walk <= (w_next == PED);
        end
    end

    assign o_LA    = r_la;
    assign o_LB    = r_lb;
    assign o_walk  = r_walk;
    assign o_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_semaforo_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_semaforo_sched
// Description : Scoreboard bench for semaforo_sched with hand-timed phase
//               sequences (TICK_DIV=4, min green 3, yellow 2, all-red 1,
//               walk 2 ticks).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_semaforo_sched;
    import semaforo_pkg::*;

    logic       clk;
    logic       rst;
    logic       req_a;
    logic       req_b;
    logic       ped_btn;
    logic       night;
    logic [1:0] la;
    logic [1:0] lb;
    logic       walk;
    logic [3:0] state;

    typedef struct {
        logic [3:0] st;
        logic [1:0] la;
        logic [1:0] lb;
        logic       walk;
        int         scn;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_mis = 0;
    int   scn   = 0;
    int   pcyc  = 0;

    semaforo_sched #(
        .TICK_DIV    (4),
        .T_MIN_GREEN (3),
        .T_YELLOW    (2),
        .T_ALLRED    (1),
        .T_WALK      (2)
    ) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_req_A   (req_a),
        .i_req_B   (req_b),
        .i_ped_btn (ped_btn),
        .i_night   (night),
        .o_LA      (la),
        .o_LB      (lb),
        .o_walk    (walk),
        .o_state   (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expected vector per cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            if ({state, la, lb, walk} !== {e.st, e.la, e.lb, e.walk}) begin
                n_mis++;
                $display("FAIL scn%0d cyc%0d: got state=%0d LA=%b LB=%b walk=%b, exp state=%0d LA=%b LB=%b walk=%b",
                         e.scn, e.cyc, state, la, lb, walk, e.st, e.la, e.lb, e.walk);
            end
        end
    end

    task automatic push(input sched_state_t st, input color_t a, input color_t b,
                        input logic w, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.st   = st;
            e.la   = a;
            e.lb   = b;
            e.walk = w;
            e.scn  = scn;
            e.cyc  = pcyc;
            exp_q.push_back(e);
            pcyc++;
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle reset; returns at the start of cycle 0 of the new scenario
    task automatic start(input int id);
        rst     = 1'b1;
        req_a   = 1'b0;
        req_b   = 1'b0;
        ped_btn = 1'b0;
        night   = 1'b0;
        cyc(1);
        rst  = 1'b0;
        scn  = id;
        pcyc = 0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 2000) begin
            cyc(1);
            g++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_mis++;
            $display("FAIL scn%0d drain: got %0d vectors pending, exp 0", scn, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        rst     = 1'b1;
        req_a   = 1'b0;
        req_b   = 1'b0;
        ped_btn = 1'b0;
        night   = 1'b0;

        // 1: idle stays in A green
        start(1);
        push(A_GRN, GREEN, RED, 1'b0, 200);
        drain();

        // 2: B demand, then alternation with both requests held
        start(2);
        req_a = 1'b1;
        req_b = 1'b1;
        push(A_GRN, GREEN,  RED,    1'b0, 12);
        push(A_YEL, YELLOW, RED,    1'b0, 8);
        push(AR_AB, RED,    RED,    1'b0, 4);
        push(B_GRN, RED,    GREEN,  1'b0, 12);
        push(B_YEL, RED,    YELLOW, 1'b0, 8);
        push(AR_BA, RED,    RED,    1'b0, 4);
        push(A_GRN, GREEN,  RED,    1'b0, 12);
        push(A_YEL, YELLOW, RED,    1'b0, 8);
        drain();

        // 3: single ped press at cycle 2; B green then holds with no demand
        start(3);
        push(A_GRN, GREEN,  RED,   1'b0, 12);
        push(A_YEL, YELLOW, RED,   1'b0, 8);
        push(AR_AB, RED,    RED,   1'b0, 4);
        push(PED,   RED,    RED,   1'b1, 8);
        push(B_GRN, RED,    GREEN, 1'b0, 24);
        cyc(2);
        ped_btn = 1'b1;
        cyc(1);
        ped_btn = 1'b0;
        drain();

        // 4: night entry at end of all-red, flashing, then exit via AR_BA
        start(4);
        push(A_GRN, GREEN,  RED,    1'b0, 12);
        push(A_YEL, YELLOW, RED,    1'b0, 8);
        push(AR_AB, RED,    RED,    1'b0, 4);
        push(NIGHT, OFF,    OFF,    1'b0, 4);
        push(NIGHT, YELLOW, YELLOW, 1'b0, 4);
        push(NIGHT, OFF,    OFF,    1'b0, 4);
        push(NIGHT, YELLOW, YELLOW, 1'b0, 4);
        push(NIGHT, OFF,    OFF,    1'b0, 1);
        push(AR_BA, RED,    RED,    1'b0, 4);
        push(A_GRN, GREEN,  RED,    1'b0, 16);
        cyc(5);
        night = 1'b1;
        cyc(35);
        night = 1'b0;
        drain();

        // 5: reset mid-yellow restarts the whole sequence
        start(5);
        req_b = 1'b1;
        push(A_GRN, GREEN,  RED,   1'b0, 12);
        push(A_YEL, YELLOW, RED,   1'b0, 4);
        push(A_GRN, GREEN,  RED,   1'b0, 12);
        push(A_YEL, YELLOW, RED,   1'b0, 8);
        push(AR_AB, RED,    RED,   1'b0, 4);
        push(B_GRN, RED,    GREEN, 1'b0, 12);
        cyc(15);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        drain();

        // 6: button held with B demand: PED at every all-red
        start(6);
        req_b   = 1'b1;
        ped_btn = 1'b1;
        push(A_GRN, GREEN,  RED,    1'b0, 12);
        push(A_YEL, YELLOW, RED,    1'b0, 8);
        push(AR_AB, RED,    RED,    1'b0, 4);
        push(PED,   RED,    RED,    1'b1, 8);
        push(B_GRN, RED,    GREEN,  1'b0, 12);
        push(B_YEL, RED,    YELLOW, 1'b0, 8);
        push(AR_BA, RED,    RED,    1'b0, 4);
        push(PED,   RED,    RED,    1'b1, 8);
        push(A_GRN, GREEN,  RED,    1'b0, 12);
        push(A_YEL, YELLOW, RED,    1'b0, 8);
        push(AR_AB, RED,    RED,    1'b0, 4);
        push(PED,   RED,    RED,    1'b1, 8);
        push(B_GRN, RED,    GREEN,  1'b0, 4);
        drain();

        // 7: presses on the PED entry cycle and during PED are not latched
        start(7);
        push(A_GRN, GREEN,  RED,   1'b0, 12);
        push(A_YEL, YELLOW, RED,   1'b0, 8);
        push(AR_AB, RED,    RED,   1'b0, 4);
        push(PED,   RED,    RED,   1'b1, 8);
        push(B_GRN, RED,    GREEN, 1'b0, 28);
        cyc(2);
        ped_btn = 1'b1;
        cyc(1);
        ped_btn = 1'b0;
        cyc(20);
        ped_btn = 1'b1;
        cyc(1);
        ped_btn = 1'b0;
        cyc(3);
        ped_btn = 1'b1;
        cyc(1);
        ped_btn = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
